oled_msg_composer: RTL and testbench

- Producer side of the OLED text path. It renders the 4x16 minesweeper board and cursor into the 512-bit ASCII message that the OLED driver consumes.
- It owns the enable/done handshake with the driver:
  - raises the update request only after the message is complete and stable;
  - holds the request until the driver reports done;
  - releases the request, then waits for done to drop before starting another frame.
- Sits between the game-state logic and the OLED driver.

---
 rtl/oled_pkg.sv | 40 ++++
 rtl/oled_msg_composer_if.sv | 25 ++
 rtl/cell_glyph.sv | 28 ++
 rtl/oled_msg_composer.sv | 119 +++++++++++
 tb/tb_oled_msg_composer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oled_pkg.sv
// Shared constants, cursor payload and FSM states for the OLED text path.
package oled_pkg;

   localparam int unsigned ROWS      = 4;
   localparam int unsigned COLS      = 16;
   localparam int unsigned CHAR_W    = 8;
   localparam int unsigned CELL_W    = 4;
   localparam int unsigned NUM_CELLS = ROWS * COLS;
   localparam int unsigned CELLS_W   = NUM_CELLS * CELL_W;
   localparam int unsigned MSG_W     = NUM_CELLS * CHAR_W;
   localparam int unsigned IDX_W     = 6;
   localparam int unsigned FRAME_W   = 8;

   localparam logic [CELL_W-1:0] CELL_HIDDEN = 4'd9;
   localparam logic [CELL_W-1:0] CELL_FLAG   = 4'd10;
   localparam logic [CELL_W-1:0] CELL_MINE   = 4'd11;

   localparam logic [CHAR_W-1:0] GLYPH_SPACE   = 8'h20;
   localparam logic [CHAR_W-1:0] GLYPH_ZERO    = 8'h2E;
   localparam logic [CHAR_W-1:0] GLYPH_DIGIT   = 8'h30;
   localparam logic [CHAR_W-1:0] GLYPH_HIDDEN  = 8'h2D;
   localparam logic [CHAR_W-1:0] GLYPH_FLAG    = 8'h46;
   localparam logic [CHAR_W-1:0] GLYPH_MINE    = 8'h2A;
   localparam logic [CHAR_W-1:0] GLYPH_INVALID = 8'h3F;
   localparam logic [CHAR_W-1:0] GLYPH_CURSOR  = 8'h5F;

   // Packs to row*COLS+col, i.e. directly comparable with the char index.
   typedef struct packed {
      logic [1:0] row;
      logic [3:0] col;
   } cursor_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COMPOSE,
      ST_WAIT_DONE,
      ST_RELEASE
   } state_t;

endpackage

// File: rtl/oled_msg_composer_if.sv
// Board/cursor inputs, rendered message and driver handshake of the composer.
interface oled_msg_composer_if;
   import oled_pkg::*;

   logic [CELLS_W-1:0] cells;
   logic [1:0]         hlX;
   logic [3:0]         hlY;
   logic               force_redraw;
   logic [MSG_W-1:0]   msg;
   logic               upd_en;
   logic               upd_done;
   logic               busy;
   logic [FRAME_W-1:0] frame_cnt;

   modport master (
      input  cells, hlX, hlY, force_redraw, upd_done,
      output msg, upd_en, busy, frame_cnt
   );

   modport slave (
      output cells, hlX, hlY, force_redraw, upd_done,
      input  msg, upd_en, busy, frame_cnt
   );

endinterface

// File: rtl/cell_glyph.sv
// Maps one 4-bit board cell code to its ASCII glyph; the cursor overrides the cell.
module cell_glyph
   import oled_pkg::*;
(
   input  logic [CELL_W-1:0] code,
   input  logic              is_cursor,
   output logic [CHAR_W-1:0] ascii
);

   always_comb begin
      ascii = GLYPH_INVALID;
      if (is_cursor) begin
         ascii = GLYPH_CURSOR;
      end else if (code == 4'd0) begin
         ascii = GLYPH_ZERO;
      end else if (code <= 4'd8) begin
         ascii = GLYPH_DIGIT + CHAR_W'(code);
      end else begin
         case (code)
            CELL_HIDDEN: ascii = GLYPH_HIDDEN;
            CELL_FLAG:   ascii = GLYPH_FLAG;
            CELL_MINE:   ascii = GLYPH_MINE;
            default:     ascii = GLYPH_INVALID;
         endcase
      end
   end

endmodule

// File: rtl/oled_msg_composer.sv
// Renders a snapshot of the board into the 64-char OLED message, one char per
// cycle, then runs the enable/done handshake with the OLED driver.
module oled_msg_composer
   import oled_pkg::*;
#(
   parameter int unsigned BLINK_CYCLES = 50_000_000
) (
   input logic                 clk,
   input logic                 reset,
   oled_msg_composer_if.master bus
);

   localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_phase;
   logic               blink_wrap_c;

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [CELLS_W-1:0] snap_cells;
   cursor_t            snap_cur;
   logic               snap_phase;
   logic               pending;
   logic               busy_q;
   logic [MSG_W-1:0]   msg_q;
   logic               upd_en_q;
   logic [FRAME_W-1:0] frame_cnt_q;

   logic               diff_c;
   logic               is_cursor_c;
   logic [CHAR_W-1:0]  glyph_c;

   // Free-running blink timer; a zero period pins the phase at "cursor shown".
   assign blink_wrap_c = (BLINK_CYCLES != 0) && (blink_cnt == BLINK_W'(BLINK_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (BLINK_CYCLES != 0) begin
         if (blink_wrap_c) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
         end
      end
   end

   assign diff_c      = (bus.cells != snap_cells) || ({bus.hlX, bus.hlY} != snap_cur);
   assign is_cursor_c = snap_phase && (idx == snap_cur);

   cell_glyph u_cell_glyph (
      .code      (snap_cells[{idx, 2'b00} +: CELL_W]),
      .is_cursor (is_cursor_c),
      .ascii     (glyph_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         idx         <= '0;
         snap_cells  <= '0;
         snap_cur    <= '0;
         snap_phase  <= 1'b1;
         pending     <= 1'b1;
         busy_q      <= 1'b0;
         msg_q       <= {NUM_CELLS{GLYPH_SPACE}};
         upd_en_q    <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         // Triggers merge into one request regardless of state.
         pending <= pending | bus.force_redraw | blink_wrap_c | diff_c;
         case (state)
            ST_IDLE: begin
               if (pending) begin
                  snap_cells <= bus.cells;
                  snap_cur   <= {bus.hlX, bus.hlY};
                  snap_phase <= blink_phase;
                  idx        <= '0;
                  // A blink toggle on this very edge is not in the snapshot yet.
                  pending    <= blink_wrap_c;
                  busy_q     <= 1'b1;
                  state      <= ST_COMPOSE;
               end
            end
            ST_COMPOSE: begin
               msg_q[{idx, 3'b000} +: CHAR_W] <= glyph_c;
               idx <= idx + IDX_W'(1);
               if (idx == IDX_W'(NUM_CELLS - 1)) begin
                  upd_en_q <= 1'b1;
                  state    <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               if (bus.upd_done) begin
                  upd_en_q    <= 1'b0;
                  frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
                  state       <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (!bus.upd_done) begin
                  busy_q <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.msg       = msg_q;
   assign bus.upd_en    = upd_en_q;
   assign bus.busy      = busy_q;
   assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_oled_msg_composer.sv
// Randomized self-checking bench for oled_msg_composer against a behavioural message model.
module tb_oled_msg_composer;
   import oled_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, reset_b;
   logic auto_a, man_done;
   logic [9:0] echo_a = '0;
   logic [9:0] echo_b = '0;

   oled_msg_composer_if bus_a ();
   oled_msg_composer_if bus_b ();

   oled_msg_composer #(.BLINK_CYCLES(0))   dut_a (.clk(clk), .reset(reset),   .bus(bus_a));
   oled_msg_composer #(.BLINK_CYCLES(100)) dut_b (.clk(clk), .reset(reset_b), .bus(bus_b));

   // Driver stand-in: done follows upd_en ten cycles later.
   always @(posedge clk) begin
      echo_a <= {echo_a[8:0], bus_a.upd_en};
      echo_b <= {echo_b[8:0], bus_b.upd_en};
   end
   assign bus_a.upd_done = auto_a ? echo_a[9] : man_done;
   assign bus_b.upd_done = echo_b[9];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [MSG_W-1:0] got, input logic [MSG_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected message straight from the glyph table and cursor rule.
   function automatic logic [MSG_W-1:0] ref_msg(input logic [CELLS_W-1:0] c, input int row,
                                                input int col, input bit ph);
      string glyphs = ".12345678-F*????";
      logic [MSG_W-1:0] m;
      for (int i = 0; i < 64; i++) begin
         int code = int'(c[i*4 +: 4]);
         byte g = glyphs[code];
         if (ph && (i == row * 16 + col)) g = 8'h5F;
         m[i*8 +: 8] = g;
      end
      return m;
   endfunction

   function automatic logic [CELLS_W-1:0] rand_cells();
      logic [CELLS_W-1:0] v;
      for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
      return v;
   endfunction

   localparam logic [MSG_W-1:0] SPACES = {64{8'h20}};

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_a(input logic [CELLS_W-1:0] c, input int r, input int col);
      bus_a.cells = c;
      bus_a.hlX   = 2'(r);
      bus_a.hlY   = 4'(col);
   endtask

   task automatic pulse_force_a();
      bus_a.force_redraw = 1'b1;
      step(1);
      bus_a.force_redraw = 1'b0;
   endtask

   task automatic wait_rise(input string tag, input int lim);
      bit seen = 0;
      for (int i = 0; i < lim; i++) begin
         step(1);
         if (bus_a.upd_en === 1'b1) begin
            seen = 1;
            break;
         end
      end
      chk(tag, MSG_W'(seen), MSG_W'(1));
   endtask

   task automatic wait_idle(input string tag, input int lim);
      bit seen = 0;
      for (int i = 0; i < lim; i++) begin
         step(1);
         if (bus_a.busy === 1'b0 && bus_a.upd_en === 1'b0) begin
            seen = 1;
            break;
         end
      end
      chk(tag, MSG_W'(seen), MSG_W'(1));
   endtask

   // Blink-instance monitor: records every upd_en rise after its reset release.
   logic [CELLS_W-1:0] b_cells;
   int                 b_row, b_col;
   logic [MSG_W-1:0]   b_msg [8];
   int                 b_cyc [8];
   logic [7:0]         b_fc  [8];
   int                 nb = 0;
   int                 cyc_b = 0;
   logic               prev_b = 1'b0;

   initial begin : mon_b
      forever begin
         @(posedge clk);
         #1;
         if (reset_b) cyc_b = 0;
         else cyc_b++;
         if (bus_b.upd_en && !prev_b && nb < 8) begin
            b_msg[nb] = bus_b.msg;
            b_cyc[nb] = cyc_b;
            b_fc[nb]  = bus_b.frame_cnt;
            nb++;
         end
         prev_b = bus_b.upd_en;
      end
   end

   initial begin : main
      logic [CELLS_W-1:0] cur_c, nxt_c;
      int cur_r, cur_col, nxt_r, nxt_col, n, hold, rises;
      logic [MSG_W-1:0] held;
      logic [95:0] got12, exp12;
      logic [7:0] fc;
      bit stable, seen, prev;
      string exp_s = ".12345678-F*";

      reset = 1'b1;
      reset_b = 1'b1;
      auto_a = 1'b1;
      man_done = 1'b0;
      bus_a.force_redraw = 1'b0;
      bus_b.force_redraw = 1'b0;
      b_cells = rand_cells();
      b_row = $urandom_range(0, 3);
      b_col = $urandom_range(0, 15);
      bus_b.cells = b_cells;
      bus_b.hlX = 2'(b_row);
      bus_b.hlY = 4'(b_col);
      cur_c = {NUM_CELLS{4'h9}};
      cur_r = 2;
      cur_col = 5;
      drive_a(cur_c, cur_r, cur_col);

      // Reset state, then first frame latency
      step(3);
      chk("rst_upd_en", MSG_W'(bus_a.upd_en), MSG_W'(0));
      chk("rst_msg", bus_a.msg, SPACES);
      chk("rst_frame_cnt", MSG_W'(bus_a.frame_cnt), MSG_W'(0));
      chk("rst_busy", MSG_W'(bus_a.busy), MSG_W'(0));
      @(negedge clk);
      reset_b = 1'b0;
      step(1);
      reset = 1'b0;
      n = 0;
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         step(1);
         n++;
         if (n == 1) chk("msg_pre_compose", bus_a.msg, SPACES);
         if (bus_a.upd_en === 1'b1) begin
            seen = 1;
            break;
         end
      end
      chk("first_rise_seen", MSG_W'(seen), MSG_W'(1));
      chk("first_latency", MSG_W'(n), MSG_W'(65));
      chk("frame_all_hidden", bus_a.msg, ref_msg(cur_c, cur_r, cur_col, 1'b1));
      chk("cursor_char", MSG_W'(bus_a.msg[37*8 +: 8]), MSG_W'(8'h5F));
      wait_idle("idle_after_first", 100);
      chk("frame_cnt_1", MSG_W'(bus_a.frame_cnt), MSG_W'(1));

      // Every glyph code, plus an invalid code in the last cell
      cur_c = {NUM_CELLS{4'h9}};
      for (int i = 0; i < 12; i++) cur_c[i*4 +: 4] = 4'(i);
      cur_c[63*4 +: 4] = 4'hF;
      cur_r = 3;
      cur_col = 0;
      drive_a(cur_c, cur_r, cur_col);
      wait_rise("codes_rise", 100);
      for (int j = 0; j < 12; j++) exp12[j*8 +: 8] = exp_s[j];
      got12 = bus_a.msg[95:0];
      chk("codes_0_11", MSG_W'(got12), MSG_W'(exp12));
      chk("code15_cell63", MSG_W'(bus_a.msg[511:504]), MSG_W'(8'h3F));
      chk("codes_frame", bus_a.msg, ref_msg(cur_c, cur_r, cur_col, 1'b1));
      wait_idle("idle_after_codes", 100);

      // Random boards; inputs change while the driver sits on the request
      auto_a = 1'b0;
      man_done = 1'b0;
      cur_c = rand_cells();
      cur_r = $urandom_range(0, 3);
      cur_col = $urandom_range(0, 15);
      drive_a(cur_c, cur_r, cur_col);
      for (int it = 0; it < 8; it++) begin
         wait_rise("rand_rise", 300);
         chk("frame_rand", bus_a.msg, ref_msg(cur_c, cur_r, cur_col, 1'b1));
         chk("busy_wait", MSG_W'(bus_a.busy), MSG_W'(1));
         held = bus_a.msg;
         nxt_c = rand_cells();
         nxt_r = $urandom_range(0, 3);
         nxt_col = $urandom_range(0, 15);
         drive_a(nxt_c, nxt_r, nxt_col);
         hold = (it == 0) ? 200 : $urandom_range(20, 120);
         stable = 1;
         repeat (hold) begin
            step(1);
            if (bus_a.msg !== held || bus_a.upd_en !== 1'b1) stable = 0;
         end
         chk("hold_stable", MSG_W'(stable), MSG_W'(1));
         fc = bus_a.frame_cnt;
         man_done = 1'b1;
         seen = 0;
         for (int k = 0; k < 5; k++) begin
            step(1);
            if (bus_a.upd_en === 1'b0) begin
               seen = 1;
               break;
            end
         end
         chk("release_seen", MSG_W'(seen), MSG_W'(1));
         chk("frame_cnt_inc", MSG_W'(bus_a.frame_cnt), MSG_W'(8'(fc + 8'd1)));
         step($urandom_range(1, 3));
         man_done = 1'b0;
         cur_c = nxt_c;
         cur_r = nxt_r;
         cur_col = nxt_col;
      end
      wait_rise("last_rand_rise", 300);
      chk("frame_rand_last", bus_a.msg, ref_msg(cur_c, cur_r, cur_col, 1'b1));
      auto_a = 1'b1;
      wait_idle("idle_after_rand", 200);

      // Several force pulses during one compose give exactly one extra frame
      fc = bus_a.frame_cnt;
      pulse_force_a();
      step(5);
      pulse_force_a();
      step(8);
      pulse_force_a();
      step(8);
      pulse_force_a();
      rises = 0;
      prev = bus_a.upd_en;
      for (int i = 0; i < 400; i++) begin
         step(1);
         if (bus_a.upd_en && !prev) rises++;
         prev = bus_a.upd_en;
      end
      chk("force_merge_rises", MSG_W'(rises), MSG_W'(2));
      chk("force_merge_cnt", MSG_W'(bus_a.frame_cnt), MSG_W'(8'(fc + 8'd2)));
      chk("force_merge_idle", MSG_W'(bus_a.busy), MSG_W'(0));

      // Reset while waiting for done
      auto_a = 1'b0;
      man_done = 1'b0;
      pulse_force_a();
      wait_rise("pre_reset_rise", 100);
      step(5);
      reset = 1'b1;
      step(1);
      chk("midrst_upd_en", MSG_W'(bus_a.upd_en), MSG_W'(0));
      chk("midrst_msg", bus_a.msg, SPACES);
      chk("midrst_frame_cnt", MSG_W'(bus_a.frame_cnt), MSG_W'(0));
      chk("midrst_busy", MSG_W'(bus_a.busy), MSG_W'(0));
      reset = 1'b0;
      auto_a = 1'b1;
      wait_rise("post_reset_rise", 100);
      chk("post_reset_frame", bus_a.msg, ref_msg(cur_c, cur_r, cur_col, 1'b1));
      wait_idle("idle_after_reset", 100);
      chk("post_reset_cnt", MSG_W'(bus_a.frame_cnt), MSG_W'(1));

      // Blinking instance: alternating cursor phase, one frame per blink period
      chk("blink_frames", MSG_W'(nb >= 6), MSG_W'(1));
      for (int k = 0; k < 6 && k < nb; k++) begin
         chk("blink_msg", b_msg[k], ref_msg(b_cells, b_row, b_col, (k % 2) == 0));
         chk("blink_cyc", MSG_W'(b_cyc[k]), MSG_W'(65 + 100 * k));
         chk("blink_fc", MSG_W'(b_fc[k]), MSG_W'(k));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
